// File: rtl/data_mem_sync_pkg.sv
// Shared types and constants for the clocked data memory.
// Clear-sweep state encoding and default geometry live here.
package data_mem_sync_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int BYTE_W     = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_e;

  function automatic int lanes(input int w);
    return w / BYTE_W;
  endfunction

endpackage

// File: rtl/data_mem_sync_clear_seq.sv
// Post-reset clear sequencer: walks every word address once,
// asserting a zero-write per cycle, then parks in RUN.
module mem_clear_seq
  import data_mem_sync_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_add
);

  clr_state_e        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    clr_we    = 1'b0;
    clr_add   = cnt;
    unique case (state)
      ST_CLEAR: begin
        busy    = 1'b1;
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

endmodule

// File: rtl/data_mem_sync.sv
// Clocked data memory: 1-cycle registered read, byte-enabled
// write, write-first forwarding and a post-reset clear sweep.
module data_mem_sync
  import data_mem_sync_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        read_add,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        write_add,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/BYTE_W-1:0] wr_be,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = lanes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_add;
  logic [DATA_W-1:0] wmerge;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_add;
  logic [DATA_W-1:0] mem_wd;

  mem_clear_seq #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_add (clr_add)
  );

  // Merged word feeds both the array and the forwarding path.
  always_comb begin
    wmerge = mem[write_add];
    for (int k = 0; k < NB; k++) begin
      if (wr_be[k])
        wmerge[k*BYTE_W +: BYTE_W] = wr_data[k*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    mem_we  = !rst && (busy ? clr_we : wr_en);
    mem_add = busy ? clr_add : write_add;
    mem_wd  = busy ? '0 : wmerge;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_add] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (busy) begin
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_valid <= 1'b1;
      if (wr_en && (read_add == write_add))
        rd_data <= wmerge;
      else
        rd_data <= mem[read_add];
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_sync.sv
// Randomised self-checking bench for data_mem_sync against an
// array reference model; second instance covers the no-sweep build.
module tb_data_mem_sync;

  logic        clk = 1'b0;
  logic        rst, rd_en, wr_en, rd_valid, busy;
  logic [3:0]  read_add, write_add;
  logic [15:0] rd_data, wr_data;
  logic [1:0]  wr_be;

  logic        rst_b, rd_en_b, wr_en_b, rd_valid_b, busy_b;
  logic [3:0]  read_add_b, write_add_b;
  logic [15:0] rd_data_b, wr_data_b;
  logic [1:0]  wr_be_b;

  int tests = 0;
  int fails = 0;

  logic [15:0] ref_mem [16];
  logic [15:0] last_rd;

  always #5 clk = ~clk;

  data_mem_sync #(.DATA_W(16), .ADDR_W(4), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .read_add(read_add),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_en(wr_en),
    .write_add(write_add), .wr_data(wr_data), .wr_be(wr_be),
    .busy(busy)
  );

  data_mem_sync #(.DATA_W(16), .ADDR_W(4), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .rd_en(rd_en_b), .read_add(read_add_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .wr_en(wr_en_b),
    .write_add(write_add_b), .wr_data(wr_data_b), .wr_be(wr_be_b),
    .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old,
                                        input logic [15:0] d,
                                        input logic [1:0] be);
    logic [15:0] m;
    m = {be[1] ? 8'hFF : 8'h00, be[0] ? 8'hFF : 8'h00};
    return (old & ~m) | (d & m);
  endfunction

  // One RUN-mode cycle: drive at negedge, check the result one cycle later.
  task automatic op(input string tag, input logic r, input logic [3:0] ra,
                    input logic w, input logic [3:0] wa,
                    input logic [15:0] wd, input logic [1:0] be);
    logic [15:0] nw;
    rd_en = r; read_add = ra;
    wr_en = w; write_add = wa; wr_data = wd; wr_be = be;
    nw = merge(ref_mem[wa], wd, be);
    if (r) last_rd = (w && ra == wa) ? nw : ref_mem[ra];
    if (w) ref_mem[wa] = nw;
    @(negedge clk);
    chk({tag, ".valid"}, 32'(rd_valid), 32'(r));
    chk({tag, ".data"}, 32'(rd_data), 32'(last_rd));
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0; wr_be = 0; wr_data = 0;
    read_add = 0; write_add = 0;
  endtask

  // Counts busy cycles after release while hammering ignored requests.
  task automatic sweep(input string tag);
    int n;
    n = 0;
    rd_en = 1; read_add = 3;
    wr_en = 1; write_add = 3; wr_data = 16'hFFFF; wr_be = 2'b11;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
      if (busy || n == 16) chk({tag, ".rdv_busy"}, 32'(rd_valid), 0);
    end
    chk({tag, ".busy_len"}, 32'(n), 16);
    idle();
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
  endtask

  initial begin
    idle();
    rd_en_b = 0; wr_en_b = 0; read_add_b = 0; write_add_b = 0;
    wr_data_b = 0; wr_be_b = 0; rst_b = 1;
    last_rd = 16'h0000;
    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst.rd_data", 32'(rd_data), 0);
    chk("rst.rd_valid", 32'(rd_valid), 0);
    chk("rst.busy", 32'(busy), 1);
    rst = 0;
    sweep("sweep0");

    for (int i = 0; i < 16; i++)
      op($sformatf("clr_rd%0d", i), 1, 4'(i), 0, 0, 0, 0);

    op("wr_beef", 0, 0, 1, 5, 16'hBEEF, 2'b11);
    op("rd_beef", 1, 5, 0, 0, 0, 0);
    chk("beef.abs", 32'(rd_data), 32'h0000BEEF);
    op("wr_1234", 0, 0, 1, 5, 16'h1234, 2'b01);
    op("rd_be34", 1, 5, 0, 0, 0, 0);
    chk("be34.abs", 32'(rd_data), 32'h0000BE34);
    op("fwd_a500", 1, 7, 1, 7, 16'hA5A5, 2'b10);
    chk("a500.abs", 32'(rd_data), 32'h0000A500);
    op("be0_nochg", 1, 5, 1, 5, 16'hFFFF, 2'b00);
    op("hold", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] ra, wa;
      ra = 4'($urandom_range(0, 15));
      wa = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      op("rand", 1'($urandom), ra, 1'($urandom), wa,
         16'($urandom), 2'($urandom));
    end

    for (int i = 0; i < 16; i++)
      op("fill", 0, 0, 1, 4'(i), 16'($urandom) | 16'h0001, 2'b11);
    op("fill_chk", 1, 9, 0, 0, 0, 0);

    rst = 1;
    @(negedge clk);
    last_rd = 16'h0000;
    chk("rst2.rd_data", 32'(rd_data), 0);
    rst = 0;
    repeat (6) @(negedge clk);
    chk("mid.busy", 32'(busy), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    sweep("sweep1");
    for (int i = 0; i < 16; i++)
      op($sformatf("clr2_rd%0d", i), 1, 4'(i), 0, 0, 0, 0);

    @(negedge clk);
    rst_b = 0;
    chk("b.busy0", 32'(busy_b), 0);
    wr_en_b = 1; write_add_b = 15; wr_data_b = 16'hC3D2; wr_be_b = 2'b11;
    @(negedge clk);
    chk("b.busy1", 32'(busy_b), 0);
    wr_en_b = 0; rd_en_b = 1; read_add_b = 15;
    @(negedge clk);
    chk("b.rd_valid", 32'(rd_valid_b), 1);
    chk("b.rd15", 32'(rd_data_b), 32'h0000C3D2);
    wr_en_b = 1; wr_data_b = 16'h0077; wr_be_b = 2'b01;
    @(negedge clk);
    chk("b.fwd15", 32'(rd_data_b), 32'h0000C377);
    rd_en_b = 0; wr_en_b = 0;
    @(negedge clk);
    chk("b.rd_idle", 32'(rd_valid_b), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
